// File: rtl/arc4_pkg.sv
// Shared types and helpers for the ARC4 encryptor: top-level states, per-byte
// sub-steps and key byte selection.
package arc4_pkg;

    localparam int KEY_BYTES_DEF = 3;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        KSA,
        RDLEN,
        PRGA,
        DONE
    } state_t;

    typedef enum logic [2:0] {
        SUB_0,
        SUB_1,
        SUB_2,
        SUB_3,
        SUB_4,
        SUB_5
    } sub_t;

    // Key is right-aligned in a 64-bit word; byte 0 is the most significant key byte.
    function automatic logic [7:0] keybyte(input logic [63:0] key, input int nbytes,
                                           input logic [7:0] n);
        int idx;
        idx = nbytes - 1 - (int'(n) % nbytes);
        return key[8*idx +: 8];
    endfunction

endpackage

// File: rtl/arc4_encrypt_s_mem.sv
// 256x8 single-port state RAM with a registered (1-cycle) read port.
module s_mem (
    input  logic       clk,
    input  logic [7:0] addr,
    input  logic [7:0] wrdata,
    input  logic       wren,
    output logic [7:0] rddata
);

    logic [7:0] mem_q [256];

    always_ff @(posedge clk) begin
        if (wren) begin
            mem_q[addr] <= wrdata;
        end
        rddata <= mem_q[addr];
    end

endmodule

// File: rtl/arc4_encrypt.sv
// ARC4 encryptor: reads a length-prefixed plaintext, writes a length-prefixed
// ciphertext using an internal single-port S box.
module arc4_encrypt
    import arc4_pkg::*;
#(
    parameter int KEY_BYTES = KEY_BYTES_DEF,
    parameter int MSG_MAX   = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    output logic                   rdy,
    input  logic [8*KEY_BYTES-1:0] key,
    output logic [7:0]             pt_addr,
    input  logic [7:0]             pt_rddata,
    output logic [7:0]             ct_addr,
    output logic [7:0]             ct_wrdata,
    output logic                   ct_wren
);

    state_t                 state_q, state_d;
    sub_t                   sub_q, sub_d;
    logic                   rdy_q, rdy_d;
    logic [8*KEY_BYTES-1:0] key_q, key_d;
    logic [7:0]             i_q, i_d, j_q, j_d, k_q, k_d, len_q, len_d;
    logic [7:0]             si_q, si_d, sj_q, sj_d;
    logic [7:0]             pt_addr_q, pt_addr_d;
    logic [7:0]             ct_addr_q, ct_addr_d, ct_wrdata_q, ct_wrdata_d;
    logic                   ct_wren_q, ct_wren_d;

    logic [7:0] s_addr, s_wrdata, s_rddata, kb, len_clip;
    logic       s_wren;

    s_mem u_s_mem (
        .clk    (clk),
        .addr   (s_addr),
        .wrdata (s_wrdata),
        .wren   (s_wren),
        .rddata (s_rddata)
    );

    always_comb begin
        state_d     = state_q;
        sub_d       = sub_q;
        rdy_d       = rdy_q;
        key_d       = key_q;
        i_d         = i_q;
        j_d         = j_q;
        k_d         = k_q;
        len_d       = len_q;
        si_d        = si_q;
        sj_d        = sj_q;
        pt_addr_d   = pt_addr_q;
        ct_addr_d   = ct_addr_q;
        ct_wrdata_d = ct_wrdata_q;
        ct_wren_d   = 1'b0;
        s_addr      = i_q;
        s_wrdata    = i_q;
        s_wren      = 1'b0;
        kb          = keybyte(64'(key_q), KEY_BYTES, i_q);
        len_clip    = (pt_rddata > 8'(MSG_MAX)) ? 8'(MSG_MAX) : pt_rddata;

        case (state_q)
            IDLE: begin
                if (en && rdy_q) begin
                    key_d   = key;
                    rdy_d   = 1'b0;
                    i_d     = 8'd0;
                    j_d     = 8'd0;
                    state_d = INIT;
                end
            end
            INIT: begin
                s_wren = 1'b1;
                i_d    = i_q + 8'd1;
                if (i_q == 8'hff) begin
                    j_d     = 8'd0;
                    sub_d   = SUB_0;
                    state_d = KSA;
                end
            end
            // Each swap reads S[i], then S[j] after all earlier writes land, so i==j is safe.
            KSA: begin
                case (sub_q)
                    SUB_0: sub_d = SUB_1;
                    SUB_1: begin
                        si_d   = s_rddata;
                        j_d    = j_q + s_rddata + kb;
                        s_addr = j_d;
                        sub_d  = SUB_2;
                    end
                    SUB_2: begin
                        s_wrdata = s_rddata;
                        s_wren   = 1'b1;
                        sub_d    = SUB_3;
                    end
                    default: begin
                        s_addr   = j_q;
                        s_wrdata = si_q;
                        s_wren   = 1'b1;
                        i_d      = i_q + 8'd1;
                        sub_d    = SUB_0;
                        if (i_q == 8'hff) begin
                            state_d = RDLEN;
                        end
                    end
                endcase
            end
            RDLEN: begin
                len_d       = len_clip;
                ct_wren_d   = 1'b1;
                ct_addr_d   = 8'd0;
                ct_wrdata_d = len_clip;
                i_d         = 8'd0;
                j_d         = 8'd0;
                k_d         = 8'd1;
                sub_d       = SUB_0;
                if (len_clip == 8'd0) begin
                    state_d = DONE;
                end else begin
                    pt_addr_d = 8'd1;
                    state_d   = PRGA;
                end
            end
            PRGA: begin
                case (sub_q)
                    SUB_0: begin
                        i_d    = i_q + 8'd1;
                        s_addr = i_d;
                        sub_d  = SUB_1;
                    end
                    SUB_1: begin
                        si_d   = s_rddata;
                        j_d    = j_q + s_rddata;
                        s_addr = j_d;
                        sub_d  = SUB_2;
                    end
                    SUB_2: begin
                        sj_d     = s_rddata;
                        s_wrdata = s_rddata;
                        s_wren   = 1'b1;
                        sub_d    = SUB_3;
                    end
                    SUB_3: begin
                        s_addr   = j_q;
                        s_wrdata = si_q;
                        s_wren   = 1'b1;
                        sub_d    = SUB_4;
                    end
                    SUB_4: begin
                        s_addr = si_q + sj_q;
                        sub_d  = SUB_5;
                    end
                    default: begin
                        ct_wren_d   = 1'b1;
                        ct_addr_d   = k_q;
                        ct_wrdata_d = pt_rddata ^ s_rddata;
                        sub_d       = SUB_0;
                        if (k_q == len_q) begin
                            state_d = DONE;
                        end else begin
                            k_d       = k_q + 8'd1;
                            pt_addr_d = k_q + 8'd1;
                        end
                    end
                endcase
            end
            default: begin
                rdy_d     = 1'b1;
                pt_addr_d = 8'd0;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sub_q       <= SUB_0;
            rdy_q       <= 1'b1;
            i_q         <= 8'd0;
            j_q         <= 8'd0;
            pt_addr_q   <= 8'd0;
            ct_addr_q   <= 8'd0;
            ct_wrdata_q <= 8'd0;
            ct_wren_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sub_q       <= sub_d;
            rdy_q       <= rdy_d;
            i_q         <= i_d;
            j_q         <= j_d;
            pt_addr_q   <= pt_addr_d;
            ct_addr_q   <= ct_addr_d;
            ct_wrdata_q <= ct_wrdata_d;
            ct_wren_q   <= ct_wren_d;
        end
        key_q <= key_d;
        k_q   <= k_d;
        len_q <= len_d;
        si_q  <= si_d;
        sj_q  <= sj_d;
    end

    assign rdy       = rdy_q;
    assign pt_addr   = pt_addr_q;
    assign ct_addr   = ct_addr_q;
    assign ct_wrdata = ct_wrdata_q;
    assign ct_wren   = ct_wren_q;

endmodule

// File: tb/tb_arc4_encrypt.sv
// Scoreboard bench for arc4_encrypt: expected ct writes are queued per run and
// popped by a monitor on every ct_wren.
module tb_arc4_encrypt;

    logic        clk = 1'b0;
    logic        rst, en, rdy, ct_wren;
    logic [23:0] key;
    logic [7:0]  pt_addr, pt_rddata, ct_addr, ct_wrdata;

    arc4_encrypt #(.KEY_BYTES(3), .MSG_MAX(255)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .rdy       (rdy),
        .key       (key),
        .pt_addr   (pt_addr),
        .pt_rddata (pt_rddata),
        .ct_addr   (ct_addr),
        .ct_wrdata (ct_wrdata),
        .ct_wren   (ct_wren)
    );

    always #5 clk = ~clk;

    logic [7:0] pt_mem [256];
    logic [7:0] ct_mem [256];
    logic [7:0] orig   [256];

    always @(posedge clk) pt_rddata <= pt_mem[pt_addr];

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         total = 0;
    int         bad = 0;
    int         wr_cnt = 0;
    logic [7:0] last_addr = 8'd0;

    // Known vector: key "Key", plaintext "Plaintext".
    logic [7:0] kv_pt [10] = '{8'd9, 8'h50, 8'h6c, 8'h61, 8'h69, 8'h6e, 8'h74, 8'h65, 8'h78, 8'h74};
    logic [7:0] kv_ct [10] = '{8'h09, 8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};

    always @(negedge clk) begin
        if (ct_wren) begin
            wr_cnt++;
            last_addr = ct_addr;
            ct_mem[ct_addr] = ct_wrdata;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write got addr=%02h data=%02h, required none", ct_addr, ct_wrdata);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.a !== ct_addr || mon_e.d !== ct_wrdata) begin
                    bad++;
                    $display("FAIL ct_write got addr=%02h data=%02h, required addr=%02h data=%02h",
                             ct_addr, ct_wrdata, mon_e.a, mon_e.d);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h required=%0h", name, got, want);
        end
    endtask

    task automatic push_exp(input logic [7:0] a, input logic [7:0] d);
        exp_t e;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
    endtask

    // Straightforward software ARC4 over pt_mem, used as the reference.
    task automatic push_model(input logic [23:0] k);
        int s[256];
        int i, j, t, len, kbv;
        len = int'(pt_mem[0]);
        push_exp(8'd0, pt_mem[0]);
        for (int n = 0; n < 256; n++) s[n] = n;
        j = 0;
        for (i = 0; i < 256; i++) begin
            kbv = int'((k >> (8 * (2 - (i % 3)))) & 24'hff);
            j = (j + s[i] + kbv) % 256;
            t = s[i]; s[i] = s[j]; s[j] = t;
        end
        i = 0;
        j = 0;
        for (int n = 1; n <= len; n++) begin
            i = (i + 1) % 256;
            j = (j + s[i]) % 256;
            t = s[i]; s[i] = s[j]; s[j] = t;
            t = s[(s[i] + s[j]) % 256];
            push_exp(8'(n), pt_mem[n] ^ 8'(t));
        end
    endtask

    task automatic start(input logic [23:0] k);
        @(posedge clk);
        #1;
        key = k;
        en  = 1'b1;
        @(posedge clk);
        #1;
        en  = 1'b0;
    endtask

    task automatic wait_rdy(input int budget, input string name, output int cyc);
        cyc = 0;
        @(negedge clk);
        while (!rdy && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        check({name, "_rdy_back"}, rdy, 1'b1);
        check({name, "_all_writes_seen"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic run(input logic [23:0] k, input string name, output int cyc);
        wr_cnt = 0;
        start(k);
        wait_rdy(4000, name, cyc);
    endtask

    task automatic load_kv();
        for (int n = 0; n < 256; n++) pt_mem[n] = 8'h00;
        for (int n = 0; n < 10; n++) pt_mem[n] = kv_pt[n];
    endtask

    task automatic push_kv();
        for (int n = 0; n < 10; n++) push_exp(8'(n), kv_ct[n]);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired got=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int cyc;
        int spam_bad;
        int snap;
        rst = 1'b1;
        en  = 1'b0;
        key = 24'h0;
        for (int n = 0; n < 256; n++) pt_mem[n] = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_rdy", rdy, 1'b1);
        check("reset_ct_wren", ct_wren, 1'b0);
        check("reset_ct_addr", ct_addr, 8'd0);
        check("reset_ct_wrdata", ct_wrdata, 8'd0);
        check("reset_pt_addr", pt_addr, 8'd0);

        // Known vector
        load_kv();
        push_kv();
        run(24'h4B6579, "kv", cyc);
        check("kv_write_count", wr_cnt, 10);

        // Round trip with a 200-byte random message
        pt_mem[0] = 8'd200;
        for (int n = 1; n < 256; n++) pt_mem[n] = 8'($urandom_range(0, 255));
        for (int n = 0; n < 256; n++) orig[n] = pt_mem[n];
        push_model(24'h000018);
        run(24'h000018, "rt_enc", cyc);
        check("rt_ct0", ct_mem[0], 8'd200);
        for (int n = 0; n <= 200; n++) pt_mem[n] = ct_mem[n];
        push_exp(8'd0, 8'd200);
        for (int n = 1; n <= 200; n++) push_exp(8'(n), orig[n]);
        run(24'h000018, "rt_dec", cyc);
        check("rt_write_count", wr_cnt, 201);

        // Empty message
        pt_mem[0] = 8'd0;
        push_exp(8'd0, 8'd0);
        run(24'h123456, "l0", cyc);
        check("l0_write_count", wr_cnt, 1);
        check("l0_within_1600", (cyc <= 1600), 1'b1);

        // Maximum length
        pt_mem[0] = 8'd255;
        for (int n = 1; n < 256; n++) pt_mem[n] = 8'($urandom_range(0, 255));
        push_model(24'hFFFFFF);
        run(24'hFFFFFF, "l255", cyc);
        check("l255_last_addr", last_addr, 8'd255);
        check("l255_write_count", wr_cnt, 256);

        // en held and toggled while busy in KSA
        pt_mem[0] = 8'd20;
        push_model(24'h000018);
        wr_cnt = 0;
        spam_bad = 0;
        start(24'h000018);
        repeat (300) @(posedge clk);
        for (int c = 0; c < 300; c++) begin
            @(posedge clk);
            #1;
            en = (c < 100) ? 1'b1 : 1'($urandom_range(0, 1));
            if (rdy) spam_bad++;
        end
        en = 1'b0;
        check("spam_rdy_low_while_busy", spam_bad, 0);
        wait_rdy(4000, "spam", cyc);
        check("spam_write_count", wr_cnt, 21);

        // Reset during PRGA at k=5, then the known vector again
        load_kv();
        push_kv();
        wr_cnt = 0;
        start(24'h4B6579);
        cyc = 0;
        while (wr_cnt < 5 && cyc < 4000) begin
            @(negedge clk);
            cyc++;
        end
        check("rst_reached_k5", (wr_cnt >= 5), 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        snap = wr_cnt;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_ct_wren", ct_wren, 1'b0);
        check("rst_rdy", rdy, 1'b1);
        check("rst_pt_addr", pt_addr, 8'd0);
        repeat (20) @(negedge clk);
        check("rst_no_more_writes", wr_cnt, snap);
        push_kv();
        run(24'h4B6579, "kv_after_rst", cyc);
        check("kv_after_rst_write_count", wr_cnt, 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
